switch_event_block: RTL and testbench

Parametrised successor to the switch serialize block. It debounces N push-button/switch channels on a shared sample tick and outputs a clean level per channel. Each channel also produces one-cycle press and release pulses, plus a press/auto-repeat event stream for menu and cursor control. It sits between the board pins and the game base logic, in the base clock domain.

---
 rtl/switch_event_block.sv | 189 ++++++++++++++++++
 tb/tb_switch_event_block.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/switch_event_block.sv
// ============================================================================
// switch_event_block
//
// Debounces pChannels push-button/switch inputs on a shared sample tick and
// turns each one into a clean level, press/release strobes and a
// press-plus-auto-repeat event stream for menu and cursor control.
// Everything runs in the iCLK domain. The raw pins are brought in through a
// two-flop synchroniser.
//
// Ports:
//   iCLK       in   1          base clock, sole clock of the block
//   iRST       in   1          asynchronous reset, active low
//   iBtn       in   pChannels  raw asynchronous switch inputs
//   iRepeatEn  in   pChannels  per-channel auto-repeat enable
//   oBtn       out  pChannels  debounced level, 1 = pressed
//   oPress     out  pChannels  one-cycle pulse on an accepted press
//   oRelease   out  pChannels  one-cycle pulse on an accepted release
//   oRepeat    out  pChannels  one-cycle event: on press, then auto-repeat
//   oTick      out  1          one-cycle sample-tick strobe
// ============================================================================
module switch_event_block #(
    parameter int pChannels      = 6,
    parameter int pMonitorTiming = 500000,
    parameter int pStableCount   = 4,
    parameter int pRepeatDelay   = 50,
    parameter int pRepeatRate    = 10,
    parameter bit pActiveLow     = 1'b1
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic [pChannels-1:0] iBtn,
    input  logic [pChannels-1:0] iRepeatEn,
    output logic [pChannels-1:0] oBtn,
    output logic [pChannels-1:0] oPress,
    output logic [pChannels-1:0] oRelease,
    output logic [pChannels-1:0] oRepeat,
    output logic                 oTick
);

    // The divider only ever holds 0..pMonitorTiming-1.
    localparam int DivWidth    = $clog2(pMonitorTiming);
    // The stable counter only ever holds 0..pStableCount-1. Keep at least
    // one bit so that a single-sample debounce still has a legal vector.
    localparam int StableWidth = (pStableCount > 1) ? $clog2(pStableCount) : 1;
    // The repeat counter is loaded with either reload value, so it must hold
    // the larger of the two.
    localparam int RepMax      = (pRepeatDelay > pRepeatRate) ? pRepeatDelay : pRepeatRate;
    localparam int RepWidth    = $clog2(RepMax + 1);

    localparam logic [DivWidth-1:0]    DivLast    = DivWidth'(pMonitorTiming - 1);
    localparam logic [StableWidth-1:0] StableLast = StableWidth'(pStableCount - 1);
    localparam logic [RepWidth-1:0]    RepDelay   = RepWidth'(pRepeatDelay);
    localparam logic [RepWidth-1:0]    RepRate    = RepWidth'(pRepeatRate);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } repeatState_t;

    logic [pChannels-1:0] syncMeta;
    logic [pChannels-1:0] sample;
    logic [DivWidth-1:0]  divCnt;
    logic                 tickNow;

    // Input conditioning. The polarity is normalised before the synchroniser,
    // so a cleared synchroniser always means "released", whatever the board
    // polarity.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            syncMeta <= '0;
            sample   <= '0;
        end else begin
            syncMeta <= iBtn ^ {pChannels{pActiveLow}};
            sample   <= syncMeta;
        end
    end

    // Shared sample-tick divider. The tick is the last count of each period,
    // so the first tick after reset comes pMonitorTiming-1 cycles in.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            divCnt <= '0;
        end else if (divCnt == DivLast) begin
            divCnt <= '0;
        end else begin
            divCnt <= divCnt + DivWidth'(1);
        end
    end

    assign tickNow = (divCnt == DivLast);
    assign oTick   = tickNow;

    // Per-channel debounce and repeat logic. The channels share only tickNow.
    for (genvar g = 0; g < pChannels; g++) begin : gChannel
        logic [StableWidth-1:0] stableCnt;
        logic [RepWidth-1:0]    repCnt;
        repeatState_t           repState;
        logic                   btnLevel;
        logic                   pressPulse;
        logic                   releasePulse;
        logic                   repeatPulse;
        logic                   differs;
        logic                   accept;

        // accept marks the tick on which the level is about to flip. Both
        // the debouncer and the repeat FSM key off it, so the press/release
        // strobes and the FSM transition land on the same edge.
        assign differs = (sample[g] != btnLevel);
        assign accept  = tickNow && differs && (stableCnt == StableLast);

        // Debouncer. Any tick that agrees with the current level restarts
        // the count, so only an unbroken run of differing samples gets
        // through. The strobes are registered alongside the level, so they
        // line up with the oBtn edge and last a single cycle.
        always_ff @(posedge iCLK or negedge iRST) begin
            if (!iRST) begin
                stableCnt    <= '0;
                btnLevel     <= 1'b0;
                pressPulse   <= 1'b0;
                releasePulse <= 1'b0;
            end else begin
                pressPulse   <= 1'b0;
                releasePulse <= 1'b0;
                if (tickNow) begin
                    if (!differs) begin
                        stableCnt <= '0;
                    end else if (accept) begin
                        btnLevel     <= ~btnLevel;
                        stableCnt    <= '0;
                        pressPulse   <= ~btnLevel;
                        releasePulse <= btnLevel;
                    end else begin
                        stableCnt <= stableCnt + StableWidth'(1);
                    end
                end
            end
        end

        // Auto-repeat FSM. The press itself always produces one event. The
        // enable is looked at on the press cycle and then only on ticks.
        // A release being accepted on this tick wins over a due repeat, so
        // no event ever coincides with oRelease.
        always_ff @(posedge iCLK or negedge iRST) begin
            if (!iRST) begin
                repState    <= IDLE;
                repCnt      <= '0;
                repeatPulse <= 1'b0;
            end else begin
                repeatPulse <= 1'b0;
                case (repState)
                    IDLE: begin
                        if (accept && !btnLevel) begin
                            repeatPulse <= 1'b1;
                            if (iRepeatEn[g]) begin
                                repState <= DELAY;
                                repCnt   <= RepDelay;
                            end
                        end
                    end
                    DELAY, REPEAT: begin
                        if (tickNow) begin
                            if (!btnLevel || accept || !iRepeatEn[g]) begin
                                repState <= IDLE;
                                repCnt   <= '0;
                            end else if (repCnt == RepWidth'(1)) begin
                                repeatPulse <= 1'b1;
                                repCnt      <= RepRate;
                                repState    <= REPEAT;
                            end else begin
                                repCnt <= repCnt - RepWidth'(1);
                            end
                        end
                    end
                    default: begin
                        repState <= IDLE;
                        repCnt   <= '0;
                    end
                endcase
            end
        end

        assign oBtn[g]     = btnLevel;
        assign oPress[g]   = pressPulse;
        assign oRelease[g] = releasePulse;
        assign oRepeat[g]  = repeatPulse;
    end

endmodule

// File: tb/tb_switch_event_block.sv
// ============================================================================
// tb_switch_event_block
//
// Directed bench for switch_event_block with pChannels=2, pMonitorTiming=4,
// pStableCount=3, pRepeatDelay=5, pRepeatRate=2 and active-low inputs.
// Cycle numbers count clock edges since the last reset release. Outputs are
// sampled 1 time unit after each rising edge, and inputs are driven at that
// same point.
// ============================================================================
module tb_switch_event_block;

    logic       iCLK = 1'b0;
    logic       iRST;
    logic [1:0] iBtn;
    logic [1:0] iRepeatEn;
    logic [1:0] oBtn;
    logic [1:0] oPress;
    logic [1:0] oRelease;
    logic [1:0] oRepeat;
    logic       oTick;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pressCnt   [2] = '{0, 0};
    int releaseCnt [2] = '{0, 0};
    int repeatCnt  [2] = '{0, 0};

    // Each entry is one checkpoint: the expected outputs at cycle cyc, and
    // the inputs to drive right after that check.
    typedef struct {
        int         cyc;
        logic [1:0] btn;
        logic [1:0] repEn;
        logic [1:0] expBtn;
        logic [1:0] expPress;
        logic [1:0] expRelease;
        logic [1:0] expRepeat;
        logic       expTick;
    } vec_t;

    vec_t vecs[$];

    always #5 iCLK = ~iCLK;

    switch_event_block #(
        .pChannels     (2),
        .pMonitorTiming(4),
        .pStableCount  (3),
        .pRepeatDelay  (5),
        .pRepeatRate   (2),
        .pActiveLow    (1'b1)
    ) dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iBtn     (iBtn),
        .iRepeatEn(iRepeatEn),
        .oBtn     (oBtn),
        .oPress   (oPress),
        .oRelease (oRelease),
        .oRepeat  (oRepeat),
        .oTick    (oTick)
    );

    function automatic vec_t mkVec(input int c, input logic [1:0] b, input logic [1:0] r,
                                   input logic [1:0] eb, input logic [1:0] ep,
                                   input logic [1:0] el, input logic [1:0] er,
                                   input logic et);
        vec_t v;
        v.cyc        = c;
        v.btn        = b;
        v.repEn      = r;
        v.expBtn     = eb;
        v.expPress   = ep;
        v.expRelease = el;
        v.expRepeat  = er;
        v.expTick    = et;
        return v;
    endfunction

    task automatic applyStimulus(input logic [1:0] btn, input logic [1:0] repEn);
        iBtn      = btn;
        iRepeatEn = repEn;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Advance one clock and tally every pulse seen, so that stray events
    // between checkpoints still show up in the pulse counts.
    task automatic stepCycle();
        @(posedge iCLK);
        #1;
        cyc++;
        for (int c = 0; c < 2; c++) begin
            pressCnt[c]   += int'(oPress[c]);
            releaseCnt[c] += int'(oRelease[c]);
            repeatCnt[c]  += int'(oRepeat[c]);
        end
        checkOutput($sformatf("pressReleaseExclusive@%0d", cyc),
                    32'(oPress & oRelease), 32'd0);
    endtask

    initial begin
        // Timeline (cycle, drive btn, drive repEn, exp oBtn, oPress, oRelease, oRepeat, oTick)
        vecs.push_back(mkVec(  1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mkVec(  2, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mkVec(  3, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mkVec(  4, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mkVec(  7, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1));
        // glitch: channel 0 low for 8 cycles (two ticks)
        vecs.push_back(mkVec(  8, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mkVec( 12, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mkVec( 16, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mkVec( 20, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        // clean press, repeat disabled
        vecs.push_back(mkVec( 24, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mkVec( 35, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mkVec( 36, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 1'b0));
        vecs.push_back(mkVec( 37, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mkVec( 56, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mkVec(124, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mkVec(135, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mkVec(136, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0));
        vecs.push_back(mkVec(137, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        // auto-repeat on channel 0, channel 1 pressed two ticks later
        vecs.push_back(mkVec(140, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mkVec(148, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mkVec(151, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mkVec(152, 2'b00, 2'b11, 2'b01, 2'b01, 2'b00, 2'b01, 1'b0));
        vecs.push_back(mkVec(159, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mkVec(160, 2'b00, 2'b11, 2'b11, 2'b10, 2'b00, 2'b10, 1'b0));
        vecs.push_back(mkVec(171, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mkVec(172, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01, 1'b0));
        vecs.push_back(mkVec(180, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 1'b0));
        vecs.push_back(mkVec(188, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 1'b0));
        vecs.push_back(mkVec(196, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 1'b0));
        vecs.push_back(mkVec(200, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mkVec(204, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 1'b0));
        vecs.push_back(mkVec(211, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mkVec(212, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b10, 1'b0));
        vecs.push_back(mkVec(216, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0));
        vecs.push_back(mkVec(220, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0));
        vecs.push_back(mkVec(227, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 1'b1));
        vecs.push_back(mkVec(228, 2'b11, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0));
        // last entry starts the reset-mid-repeat sequence on channel 0
        vecs.push_back(mkVec(236, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));

        // Reset held low while the inputs wiggle: nothing may leak out.
        iRST = 1'b0;
        applyStimulus(2'b11, 2'b00);
        for (int i = 0; i < 6; i++) begin
            @(posedge iCLK);
            #1;
            applyStimulus(2'(i), 2'(i + 1));
            checkOutput($sformatf("resetQuiet%0d", i),
                        {23'd0, oBtn, oPress, oRelease, oRepeat, oTick}, 32'd0);
        end
        applyStimulus(2'b11, 2'b00);
        @(posedge iCLK);
        #1;
        iRST = 1'b1;
        cyc  = 0;

        foreach (vecs[k]) begin
            while (cyc < vecs[k].cyc) stepCycle();
            checkOutput($sformatf("oBtn@%0d", cyc),     32'(oBtn),     32'(vecs[k].expBtn));
            checkOutput($sformatf("oPress@%0d", cyc),   32'(oPress),   32'(vecs[k].expPress));
            checkOutput($sformatf("oRelease@%0d", cyc), 32'(oRelease), 32'(vecs[k].expRelease));
            checkOutput($sformatf("oRepeat@%0d", cyc),  32'(oRepeat),  32'(vecs[k].expRepeat));
            checkOutput($sformatf("oTick@%0d", cyc),    32'(oTick),    32'(vecs[k].expTick));
            applyStimulus(vecs[k].btn, vecs[k].repEn);
        end

        // Whole-timeline pulse totals catch any event between checkpoints.
        checkOutput("pressCount0",   32'(pressCnt[0]),   32'd2);
        checkOutput("pressCount1",   32'(pressCnt[1]),   32'd1);
        checkOutput("releaseCount0", 32'(releaseCnt[0]), 32'd2);
        checkOutput("releaseCount1", 32'(releaseCnt[1]), 32'd1);
        checkOutput("repeatCount0",  32'(repeatCnt[0]),  32'd7);
        checkOutput("repeatCount1",  32'(repeatCnt[1]),  32'd7);

        // Reset mid-repeat: press with repeat enabled, get into REPEAT.
        while (oPress[0] !== 1'b1 && cyc < 300) stepCycle();
        checkOutput("pressBeforeResetCycle", 32'(cyc), 32'd248);
        while (cyc < 278) stepCycle();
        checkOutput("heldBeforeReset", 32'(oBtn), 32'b01);
        checkOutput("repeatsBeforeReset", 32'(repeatCnt[0]), 32'd10);

        // Asynchronous assertion mid-cycle clears outputs before any edge.
        #2;
        iRST = 1'b0;
        #1;
        checkOutput("asyncResetClear",
                    {23'd0, oBtn, oPress, oRelease, oRepeat, oTick}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge iCLK);
            #1;
            checkOutput($sformatf("midResetQuiet%0d", i),
                        {23'd0, oBtn, oPress, oRelease, oRepeat, oTick}, 32'd0);
        end

        // Release reset with channel 0 still held: a fresh press follows.
        iRST = 1'b1;
        cyc  = 0;
        while (oPress[0] !== 1'b1 && cyc < 40) stepCycle();
        checkOutput("pressAfterResetCycle", 32'(cyc), 32'd12);
        checkOutput("repeatAfterReset", 32'(oRepeat), 32'b01);
        checkOutput("noReleaseAcrossReset", 32'(releaseCnt[0]), 32'd2);
        checkOutput("pressCountFinal", 32'(pressCnt[0]), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
